// File: rtl/axi_req_arbiter.sv
// Round-robin front end that shares the single-port AXI master between fetch and data requesters.
// Commands are latched at grant; a flush squashes a fetch result but never aborts the bus transfer.
module axi_req_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter logic [3:0]  ID_INST = 4'd0,
  parameter logic [3:0]  ID_DATA = 4'd1
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              flush_i,
  input  logic              inst_req_i,
  input  logic [ADDR_W-1:0] inst_addr_i,
  output logic              inst_done_o,
  output logic [DATA_W-1:0] inst_rdata_o,
  input  logic              data_req_i,
  input  logic [ADDR_W-1:0] data_addr_i,
  input  logic              data_we_i,
  input  logic [DATA_W-1:0] data_wdata_i,
  input  logic [3:0]        data_sel_i,
  output logic              data_done_o,
  output logic [DATA_W-1:0] data_rdata_o,
  output logic              m_ce_o,
  output logic [ADDR_W-1:0] m_addr_o,
  output logic              m_we_o,
  output logic [DATA_W-1:0] m_wdata_o,
  output logic [3:0]        m_sel_o,
  output logic [3:0]        m_id_o,
  input  logic              m_stall_i,
  input  logic [DATA_W-1:0] m_rdata_i
);

  typedef enum logic [1:0] {StIdle, StBusyI, StBusyD} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                we_q, we_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [3:0]          sel_q, sel_d;
  logic                last_data_q, last_data_d;
  logic                squash_q, squash_d;
  logic                inst_done_q, inst_done_d;
  logic [DATA_W-1:0]   inst_rdata_q, inst_rdata_d;
  logic                data_done_q, data_done_d;
  logic [DATA_W-1:0]   data_rdata_q, data_rdata_d;
  logic                inst_elig, data_elig;

  // A request seen in its own done cycle is the tail of the finished one, not a new request.
  assign inst_elig = inst_req_i & ~inst_done_q & ~flush_i;
  assign data_elig = data_req_i & ~data_done_q;

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    we_d         = we_q;
    wdata_d      = wdata_q;
    sel_d        = sel_q;
    last_data_d  = last_data_q;
    squash_d     = squash_q;
    inst_done_d  = 1'b0;
    inst_rdata_d = inst_rdata_q;
    data_done_d  = 1'b0;
    data_rdata_d = data_rdata_q;
    unique case (state_q)
      StIdle: begin
        if (inst_elig && (!data_elig || last_data_q)) begin
          state_d     = StBusyI;
          addr_d      = inst_addr_i;
          we_d        = 1'b0;
          wdata_d     = '0;
          sel_d       = 4'hF;
          last_data_d = 1'b0;
          squash_d    = 1'b0;
        end else if (data_elig) begin
          state_d     = StBusyD;
          addr_d      = data_addr_i;
          we_d        = data_we_i;
          wdata_d     = data_wdata_i;
          sel_d       = data_sel_i;
          last_data_d = 1'b1;
        end
      end
      StBusyI: begin
        if (!m_stall_i) begin
          state_d  = StIdle;
          squash_d = 1'b0;
          if (!squash_q && !flush_i) begin
            inst_done_d  = 1'b1;
            inst_rdata_d = m_rdata_i;
          end
        end else if (flush_i) begin
          squash_d = 1'b1;
        end
      end
      StBusyD: begin
        if (!m_stall_i) begin
          state_d      = StIdle;
          data_done_d  = 1'b1;
          data_rdata_d = m_rdata_i;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      sel_q        <= '0;
      last_data_q  <= 1'b1;
      squash_q     <= 1'b0;
      inst_done_q  <= 1'b0;
      inst_rdata_q <= '0;
      data_done_q  <= 1'b0;
      data_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      we_q         <= we_d;
      wdata_q      <= wdata_d;
      sel_q        <= sel_d;
      last_data_q  <= last_data_d;
      squash_q     <= squash_d;
      inst_done_q  <= inst_done_d;
      inst_rdata_q <= inst_rdata_d;
      data_done_q  <= data_done_d;
      data_rdata_q <= data_rdata_d;
    end
  end

  always_comb begin
    m_ce_o    = 1'b0;
    m_addr_o  = '0;
    m_we_o    = 1'b0;
    m_wdata_o = '0;
    m_sel_o   = '0;
    m_id_o    = '0;
    if (state_q != StIdle) begin
      m_ce_o    = 1'b1;
      m_addr_o  = addr_q;
      m_we_o    = we_q;
      m_wdata_o = wdata_q;
      m_sel_o   = sel_q;
      m_id_o    = (state_q == StBusyI) ? ID_INST : ID_DATA;
    end
  end

  assign inst_done_o  = inst_done_q;
  assign inst_rdata_o = inst_rdata_q;
  assign data_done_o  = data_done_q;
  assign data_rdata_o = data_rdata_q;

endmodule

// File: tb/tb_axi_req_arbiter.sv
// Bench for axi_req_arbiter: a fixed vector table, directed corner sequences, and random traffic
// checked against a transaction-level model of the arbiter.
module tb_axi_req_arbiter;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        flush = 1'b0;
  logic        ireq = 1'b0;
  logic [31:0] iaddr = '0;
  logic        dreq = 1'b0;
  logic [31:0] daddr = '0;
  logic        dwe = 1'b0;
  logic [31:0] dwdata = '0;
  logic [3:0]  dsel = '0;
  logic        stall = 1'b0;
  logic [31:0] mrd = '0;

  logic        inst_done, data_done, m_ce, m_we;
  logic [31:0] inst_rdata, data_rdata, m_addr, m_wdata;
  logic [3:0]  m_sel, m_id;

  int n_tests = 0;
  int n_fail = 0;

  always #5 aclk = ~aclk;

  axi_req_arbiter dut (
    .aclk         (aclk),
    .aresetn      (aresetn),
    .flush_i      (flush),
    .inst_req_i   (ireq),
    .inst_addr_i  (iaddr),
    .inst_done_o  (inst_done),
    .inst_rdata_o (inst_rdata),
    .data_req_i   (dreq),
    .data_addr_i  (daddr),
    .data_we_i    (dwe),
    .data_wdata_i (dwdata),
    .data_sel_i   (dsel),
    .data_done_o  (data_done),
    .data_rdata_o (data_rdata),
    .m_ce_o       (m_ce),
    .m_addr_o     (m_addr),
    .m_we_o       (m_we),
    .m_wdata_o    (m_wdata),
    .m_sel_o      (m_sel),
    .m_id_o       (m_id),
    .m_stall_i    (stall),
    .m_rdata_i    (mrd)
  );

  logic [139:0] dut_vec;
  assign dut_vec = {m_ce, m_addr, m_we, m_wdata, m_sel, m_id,
                    inst_done, inst_rdata, data_done, data_rdata};

  task automatic chk(input string name, input logic [139:0] got, input logic [139:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Transaction-level model: which requester owns the bus and the command it was granted with.
  int          own;          // 0 none, 1 fetch, 2 data
  logic [31:0] tx_addr, tx_wdata;
  logic        tx_we;
  logic [3:0]  tx_sel;
  bit          fetch_killed, data_won_last;
  logic        e_idone, e_ddone;
  logic [31:0] e_ird, e_drd;

  task automatic model_step();
    bit want_i, want_d;
    if (!aresetn) begin
      own = 0; tx_addr = '0; tx_wdata = '0; tx_we = 1'b0; tx_sel = '0;
      fetch_killed = 1'b0; data_won_last = 1'b1;
      e_idone = 1'b0; e_ddone = 1'b0; e_ird = '0; e_drd = '0;
      return;
    end
    want_i = ireq && !e_idone && !flush;
    want_d = dreq && !e_ddone;
    e_idone = 1'b0;
    e_ddone = 1'b0;
    if (own == 0) begin
      if (want_i && !(want_d && !data_won_last)) begin
        own = 1; tx_addr = iaddr; tx_we = 1'b0; tx_wdata = '0; tx_sel = 4'hF;
        data_won_last = 1'b0; fetch_killed = 1'b0;
      end else if (want_d) begin
        own = 2; tx_addr = daddr; tx_we = dwe; tx_wdata = dwdata; tx_sel = dsel;
        data_won_last = 1'b1;
      end
    end else if (!stall) begin
      if (own == 1) begin
        if (!fetch_killed && !flush) begin
          e_idone = 1'b1;
          e_ird = mrd;
        end
        fetch_killed = 1'b0;
      end else begin
        e_ddone = 1'b1;
        e_drd = mrd;
      end
      own = 0;
    end else if (own == 1 && flush) begin
      fetch_killed = 1'b1;
    end
  endtask

  function automatic logic [139:0] exp_vec();
    logic b;
    b = (own != 0);
    return {b, b ? tx_addr : 32'h0, b ? tx_we : 1'b0, b ? tx_wdata : 32'h0,
            b ? tx_sel : 4'h0, (own == 2) ? 4'd1 : 4'd0,
            e_idone, e_ird, e_ddone, e_drd};
  endfunction

  task automatic cycle();
    model_step();
    @(posedge aclk);
    #1;
    chk("model", dut_vec, exp_vec());
  endtask

  task automatic quiet();
    ireq = 1'b0; dreq = 1'b0; flush = 1'b0; stall = 1'b0; dwe = 1'b0;
    dsel = 4'hF; dwdata = '0; mrd = '0;
  endtask

  typedef struct {
    logic        rst, ireq;
    logic [31:0] iaddr;
    logic        dreq;
    logic [31:0] daddr;
    logic        flush, stall;
    logic [31:0] mrd;
    logic        ce;
    logic [3:0]  id;
    logic [31:0] addr;
    logic        idone;
    logic [31:0] ird;
    logic        ddone;
    logic [31:0] drd;
  } vec_t;

  vec_t tbl[16];

  initial begin
    logic [139:0] e;
    //          rst ireq iaddr          dreq daddr  fl st mrd            ce id addr
    //          idone ird               ddone drd
    tbl[0]  = '{1, 0, 32'h0,        0, 32'h0,  0, 0, 32'h0,        0, 0, 32'h0,
                0, 32'h0,        0, 32'h0};
    tbl[1]  = '{0, 1, 32'h1C000010, 1, 32'h40, 0, 0, 32'h0,        1, 0, 32'h1C000010,
                0, 32'h0,        0, 32'h0};
    tbl[2]  = '{0, 1, 32'h1C000010, 1, 32'h40, 0, 0, 32'h11111111, 0, 0, 32'h0,
                1, 32'h11111111, 0, 32'h0};
    tbl[3]  = '{0, 1, 32'h1C000010, 1, 32'h40, 0, 0, 32'h0,        1, 1, 32'h40,
                0, 32'h11111111, 0, 32'h0};
    tbl[4]  = '{0, 0, 32'h0,        1, 32'h40, 0, 0, 32'h22222222, 0, 0, 32'h0,
                0, 32'h11111111, 1, 32'h22222222};
    tbl[5]  = '{0, 1, 32'h1C000000, 0, 32'h0,  0, 1, 32'h0,        1, 0, 32'h1C000000,
                0, 32'h11111111, 0, 32'h22222222};
    tbl[6]  = '{0, 1, 32'h1C000000, 0, 32'h0,  0, 1, 32'h0,        1, 0, 32'h1C000000,
                0, 32'h11111111, 0, 32'h22222222};
    tbl[7]  = tbl[6];
    tbl[8]  = tbl[6];
    tbl[9]  = '{0, 1, 32'h1C000000, 0, 32'h0,  0, 0, 32'hDEADBEEF, 0, 0, 32'h0,
                1, 32'hDEADBEEF, 0, 32'h22222222};
    tbl[10] = '{0, 0, 32'h0,        0, 32'h0,  0, 0, 32'h0,        0, 0, 32'h0,
                0, 32'hDEADBEEF, 0, 32'h22222222};
    tbl[11] = '{0, 1, 32'h1C000030, 1, 32'h48, 0, 0, 32'h0,        1, 1, 32'h48,
                0, 32'hDEADBEEF, 0, 32'h22222222};
    tbl[12] = '{0, 1, 32'h1C000030, 1, 32'h48, 0, 0, 32'h33333333, 0, 0, 32'h0,
                0, 32'hDEADBEEF, 1, 32'h33333333};
    tbl[13] = '{0, 1, 32'h1C000030, 1, 32'h48, 0, 0, 32'h0,        1, 0, 32'h1C000030,
                0, 32'hDEADBEEF, 0, 32'h33333333};
    tbl[14] = '{0, 1, 32'h1C000030, 0, 32'h0,  0, 0, 32'h44444444, 0, 0, 32'h0,
                1, 32'h44444444, 0, 32'h33333333};
    tbl[15] = '{0, 0, 32'h0,        0, 32'h0,  0, 0, 32'h0,        0, 0, 32'h0,
                0, 32'h44444444, 0, 32'h33333333};

    quiet();
    for (int i = 0; i < 16; i++) begin
      aresetn = !tbl[i].rst; ireq = tbl[i].ireq; iaddr = tbl[i].iaddr;
      dreq = tbl[i].dreq; daddr = tbl[i].daddr; flush = tbl[i].flush;
      stall = tbl[i].stall; mrd = tbl[i].mrd;
      @(posedge aclk);
      #1;
      e = {tbl[i].ce, tbl[i].addr, 1'b0, 32'h0, tbl[i].ce ? 4'hF : 4'h0, tbl[i].id,
           tbl[i].idone, tbl[i].ird, tbl[i].ddone, tbl[i].drd};
      chk($sformatf("vec%0d", i), dut_vec, e);
    end

    // Write whose requester inputs change while the transfer is in flight.
    quiet(); aresetn = 1'b0; cycle(); aresetn = 1'b1;
    dreq = 1'b1; daddr = 32'h80; dwe = 1'b1; dwdata = 32'h12345678; dsel = 4'b0011; stall = 1'b1;
    cycle();
    daddr = 32'hFFFF0000; dwe = 1'b0; dwdata = 32'h0; dsel = 4'hC;
    repeat (2) begin
      cycle();
      chk("wr_latched", {m_addr, m_wdata, m_sel, m_we, m_id},
          {32'h80, 32'h12345678, 4'b0011, 1'b1, 4'd1});
    end
    stall = 1'b0; cycle();
    dreq = 1'b0; cycle();

    // Flush during a fetch, then a redirected fetch.
    ireq = 1'b1; iaddr = 32'h1C000000; stall = 1'b1; cycle();
    flush = 1'b1; iaddr = 32'h1C000004; cycle();
    flush = 1'b0; cycle();
    stall = 1'b0; mrd = 32'hBAD0BAD0; cycle();
    chk("flush_nodone", inst_done, 1'b0);
    mrd = 32'hCAFEF00D; cycle();
    chk("refetch_addr", m_addr, 32'h1C000004);
    cycle();
    chk("refetch_done", {inst_done, inst_rdata}, {1'b1, 32'hCAFEF00D});
    ireq = 1'b0; cycle();

    // Data request held high through its done cycle.
    dreq = 1'b1; daddr = 32'h100; dsel = 4'hF; mrd = 32'h5A5A5A5A;
    cycle(); cycle();
    chk("held_done", data_done, 1'b1);
    cycle();
    chk("held_no_reissue", m_ce, 1'b0);
    cycle();
    chk("held_regrant", {m_ce, m_id}, {1'b1, 4'd1});
    dreq = 1'b0; cycle(); cycle();

    // Reset in the middle of a data transfer.
    dreq = 1'b1; daddr = 32'h200; stall = 1'b1; cycle(); cycle();
    aresetn = 1'b0; cycle();
    chk("rst_mid", dut_vec, 140'h0);
    aresetn = 1'b1; ireq = 1'b1; iaddr = 32'h1C000100; stall = 1'b0; cycle();
    chk("rst_tie", {m_ce, m_id, m_addr}, {1'b1, 4'd0, 32'h1C000100});
    ireq = 1'b0; dreq = 1'b0; cycle(); cycle(); cycle();

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      if (!ireq || e_idone) begin
        ireq = ($urandom_range(0, 2) != 0);
        iaddr = {$urandom_range(0, 32'h3FFF), 2'b00};
      end
      if (!dreq || e_ddone) begin
        dreq = ($urandom_range(0, 2) != 0);
        daddr = $urandom; dwe = $urandom_range(0, 1);
        dwdata = $urandom; dsel = 4'($urandom_range(0, 15));
      end
      flush = ($urandom_range(0, 9) == 0);
      if (flush) iaddr = {$urandom_range(0, 32'h3FFF), 2'b00};
      stall = $urandom_range(0, 1);
      mrd = $urandom;
      aresetn = ($urandom_range(0, 299) != 0);
      cycle();
    end
    aresetn = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
